// File: rtl/i2s_tx.sv
// I2S transmitter: holds one stereo pair behind a valid/ready handshake and
// shifts it out MSB-first with a one-BCLK delay after LRCK. Repeats the last pair on underrun.
module i2s_tx #(
  parameter int WD       = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [WD-1:0] l_data_i,
  input  logic [WD-1:0] r_data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          bclk_o,
  output logic          lrck_o,
  output logic          sdata_o,
  output logic          frame_o,
  output logic          underrun_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic [WD-1:0]    word_l_q, word_l_d;
  logic [WD-1:0]    word_r_q, word_r_d;
  logic             full_q, full_d;
  logic [WD-1:0]    buf_l_q, buf_l_d;
  logic [WD-1:0]    buf_r_q, buf_r_d;
  logic [WD-1:0]    last_l_q, last_l_d;
  logic [WD-1:0]    last_r_q, last_r_d;
  logic             frame_q, frame_d;
  logic             underrun_q, underrun_d;

  logic             term;
  logic             fall_tick;
  logic             frame_start;
  logic             accept;
  logic [BIT_W-1:0] pos;
  logic [WD-1:0]    chan;

  assign term        = en_i && (div_cnt_q == DIV_LAST);
  assign fall_tick   = term && bclk_q;
  assign frame_start = fall_tick && (bit_cnt_q == BIT_LAST);
  assign accept      = valid_i && !full_q;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    word_l_d   = word_l_q;
    word_r_d   = word_r_q;
    full_d     = full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
    frame_d    = frame_start;
    underrun_d = 1'b0;
    pos        = '0;
    chan       = '0;

    if (term) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else if (en_i) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (fall_tick) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end

    if (accept && !frame_start) begin
      buf_l_d = l_data_i;
      buf_r_d = r_data_i;
      full_d  = 1'b1;
    end

    // Frame load: buffered pair first, else a same-cycle bypass, else repeat.
    if (frame_start) begin
      if (full_q) begin
        word_l_d = buf_l_q;
        word_r_d = buf_r_q;
        last_l_d = buf_l_q;
        last_r_d = buf_r_q;
        full_d   = 1'b0;
      end else if (accept) begin
        word_l_d = l_data_i;
        word_r_d = r_data_i;
        last_l_d = l_data_i;
        last_r_d = r_data_i;
      end else begin
        word_l_d   = last_l_q;
        word_r_d   = last_r_q;
        underrun_d = 1'b1;
      end
    end

    if (fall_tick) begin
      lrck_d  = (bit_cnt_d >= SLOT);
      pos     = lrck_d ? (bit_cnt_d - SLOT) : bit_cnt_d;
      chan    = lrck_d ? word_r_d : word_l_d;
      sdata_d = 1'b0;
      for (int i = 0; i < WD; i++) begin
        if (pos == BIT_W'(WD - i)) sdata_d = chan[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_LAST;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      word_l_q   <= '0;
      word_r_q   <= '0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      last_l_q   <= '0;
      last_r_q   <= '0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      word_l_q   <= word_l_d;
      word_r_q   <= word_r_d;
      full_q     <= full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready_o    = !full_q;
  assign bclk_o     = bclk_q;
  assign lrck_o     = lrck_q;
  assign sdata_o    = sdata_q;
  assign frame_o    = frame_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at WD=8, SLOT_W=10, BCLK_DIV=2 (4-cycle BCLK, 80-cycle frame).
module tb_i2s_tx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic [7:0] l_data_i = 8'h00;
  logic [7:0] r_data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o, bclk_o, lrck_o, sdata_o, frame_o, underrun_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] sent_q[$];
  logic        stop_drv;

  localparam logic [19:0] LR_PATTERN = 20'hFFC00;
  localparam logic [19:0] PAD_MASK   = 20'h80601;
  localparam logic [19:0] A5_3C_SEQ  = 20'h1E14A;

  i2s_tx #(.WD(8), .SLOT_W(10), .BCLK_DIV(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .l_data_i(l_data_i), .r_data_i(r_data_i), .valid_i(valid_i),
    .ready_o(ready_o), .bclk_o(bclk_o), .lrck_o(lrck_o), .sdata_o(sdata_o),
    .frame_o(frame_o), .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] slot_word(input logic [19:0] s, input int base);
    logic [7:0] w;
    for (int p = 1; p <= 8; p++) w[8-p] = s[base+p];
    return w;
  endfunction

  task automatic wait_frame(output logic to);
    int n = 0;
    while (!frame_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    to = !frame_o;
  endtask

  // Samples one whole frame, one sample per bit starting at the frame_o cycle.
  task automatic capture(input int stall_bit, output logic [19:0] seq, output logic [19:0] lr,
                         output logic ur, output logic rdy0, output logic rdy_mid,
                         output int t0, output logic frozen_ok, output logic to);
    logic sb, sl, sd;
    seq = '0; lr = '0; ur = 1'b0; rdy0 = 1'b0; rdy_mid = 1'b0; t0 = 0; frozen_ok = 1'b1;
    wait_frame(to);
    if (to) return;
    ur   = underrun_o;
    rdy0 = ready_o;
    t0   = cyc;
    for (int b = 0; b < 20; b++) begin
      seq[b] = sdata_o;
      lr[b]  = lrck_o;
      if (b == 10) rdy_mid = ready_o;
      if (b < 19) begin
        if (b == stall_bit) begin
          @(negedge clk_i);
          sb = bclk_o; sl = lrck_o; sd = sdata_o;
          en_i = 1'b0;
          repeat (7) begin
            @(negedge clk_i);
            if (bclk_o !== sb || lrck_o !== sl || sdata_o !== sd) frozen_ok = 1'b0;
          end
          en_i = 1'b1;
          repeat (3) @(negedge clk_i);
        end else begin
          repeat (4) @(negedge clk_i);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to;
    int t0, n;
    valid_i = 1'b0;
    en_i = 1'b1;
    do_reset();
    checks++;
    if ({bclk_o, lrck_o, sdata_o, frame_o, underrun_o} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {bclk_o, lrck_o, sdata_o, frame_o, underrun_o});
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", ready_o);
    end
    n = 0;
    while (!frame_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL first_frame_latency: got %0d expected 4", n);
    end
    capture(-1, seq, lr, ur, rdy0, rdy_mid, t0, fz, to);
    checks++;
    if (to || ur !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_frame_underrun: got %b timeout %b expected 1", ur, to);
    end
    checks++;
    if (seq !== 20'h0) begin
      errors++;
      $display("[TB] FAIL first_frame_zeros: got %h expected 00000", seq);
    end
  endtask

  task automatic test_normal_stream();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to, prev;
    int t0, t_prev, n;
    l_data_i = 8'hA5; r_data_i = 8'h3C; valid_i = 1'b1;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      capture(-1, seq, lr, ur, rdy0, rdy_mid, t0, fz, to);
      checks++;
      if (to || seq !== A5_3C_SEQ) begin
        errors++;
        $display("[TB] FAIL normal_sdata[%0d]: got %h expected %h", f, seq, A5_3C_SEQ);
      end
      checks++;
      if (lr !== LR_PATTERN) begin
        errors++;
        $display("[TB] FAIL normal_lrck[%0d]: got %h expected %h", f, lr, LR_PATTERN);
      end
      checks++;
      if (ur !== 1'b0 || rdy0 !== 1'b1 || rdy_mid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL normal_flags[%0d]: underrun %b ready0 %b readymid %b expected 0 1 0", f, ur, rdy0, rdy_mid);
      end
      if (f > 0) begin
        checks++;
        if (t0 - t_prev != 80) begin
          errors++;
          $display("[TB] FAIL normal_frame_period: got %0d expected 80", t0 - t_prev);
        end
      end
      t_prev = t0;
    end
    n = 0;
    prev = bclk_o;
    while (!(prev == 1'b0 && bclk_o == 1'b1) && n < 20) begin
      prev = bclk_o;
      @(negedge clk_i);
      n++;
    end
    n = 0;
    prev = bclk_o;
    do begin
      prev = bclk_o;
      @(negedge clk_i);
      n++;
    end while (!(prev == 1'b0 && bclk_o == 1'b1) && n < 20);
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL bclk_period: got %0d expected 4", n);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_underrun();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to;
    int t0;
    l_data_i = 8'h7F; r_data_i = 8'h80; valid_i = 1'b1;
    do_reset();
    @(negedge clk_i);
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underrun_accept_ready: got %b expected 0", ready_o);
    end
    for (int f = 0; f < 3; f++) begin
      capture(-1, seq, lr, ur, rdy0, rdy_mid, t0, fz, to);
      checks++;
      if (to || slot_word(seq, 0) !== 8'h7F || slot_word(seq, 10) !== 8'h80 || (seq & PAD_MASK) !== 20'h0) begin
        errors++;
        $display("[TB] FAIL underrun_data[%0d]: got %h/%h expected 7f/80", f, slot_word(seq, 0), slot_word(seq, 10));
      end
      checks++;
      if (ur !== (f > 0)) begin
        errors++;
        $display("[TB] FAIL underrun_pulse[%0d]: got %b expected %b", f, ur, (f > 0));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to;
    int t0;
    wait_frame(to);
    repeat (79) @(negedge clk_i);
    l_data_i = 8'h01; r_data_i = 8'hFE; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    checks++;
    if (to || frame_o !== 1'b1 || underrun_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_flags: frame %b underrun %b ready %b expected 1 0 1", frame_o, underrun_o, ready_o);
    end
    capture(-1, seq, lr, ur, rdy0, rdy_mid, t0, fz, to);
    checks++;
    if (to || slot_word(seq, 0) !== 8'h01 || slot_word(seq, 10) !== 8'hFE) begin
      errors++;
      $display("[TB] FAIL simul_data: got %h/%h expected 01/fe", slot_word(seq, 0), slot_word(seq, 10));
    end
    checks++;
    if (rdy_mid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_ready_mid: got %b expected 1", rdy_mid);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to, hs;
    logic [15:0] expv, gotv;
    int t0;
    stop_drv = 1'b0;
    sent_q.delete();
    fork
      begin
        l_data_i = 8'h10; r_data_i = 8'hEF; valid_i = 1'b1;
        hs = 1'b0;
        while (!stop_drv) begin
          if (hs) begin
            l_data_i = l_data_i + 8'd1;
            r_data_i = r_data_i - 8'd1;
          end
          hs = ready_o;
          if (hs) sent_q.push_back({l_data_i, r_data_i});
          @(negedge clk_i);
        end
        valid_i = 1'b0;
      end
      begin
        for (int f = 0; f < 4; f++) begin
          capture(-1, seq, lr, ur, rdy0, rdy_mid, t0, fz, to);
          gotv = {slot_word(seq, 0), slot_word(seq, 10)};
          expv = (sent_q.size() > 0) ? sent_q.pop_front() : 16'hxxxx;
          checks++;
          if (to || gotv !== expv) begin
            errors++;
            $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", f, gotv, expv);
          end
          checks++;
          if (ur !== 1'b0 || rdy0 !== 1'b1 || rdy_mid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_flags[%0d]: underrun %b ready0 %b readymid %b expected 0 1 0", f, ur, rdy0, rdy_mid);
          end
        end
        stop_drv = 1'b1;
      end
    join
  endtask

  task automatic test_en_gating();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to;
    int t1, t2;
    l_data_i = 8'hA5; r_data_i = 8'h3C; valid_i = 1'b1;
    do_reset();
    capture(5, seq, lr, ur, rdy0, rdy_mid, t1, fz, to);
    checks++;
    if (to || fz !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_frozen: got %b expected 1", fz);
    end
    checks++;
    if (seq !== A5_3C_SEQ || lr !== LR_PATTERN) begin
      errors++;
      $display("[TB] FAIL en_stalled_frame: got %h/%h expected %h/%h", seq, lr, A5_3C_SEQ, LR_PATTERN);
    end
    capture(-1, seq, lr, ur, rdy0, rdy_mid, t2, fz, to);
    checks++;
    if (to || t2 - t1 != 87) begin
      errors++;
      $display("[TB] FAIL en_frame_length: got %0d expected 87", t2 - t1);
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] seq, lr;
    logic ur, rdy0, rdy_mid, fz, to;
    int t0, n;
    l_data_i = 8'h55; r_data_i = 8'hAA; valid_i = 1'b1;
    wait_frame(to);
    repeat (52) @(negedge clk_i);
    checks++;
    if (to || ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_buffer_full: got ready %b expected 0", ready_o);
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if ({bclk_o, lrck_o, sdata_o, frame_o, underrun_o, ready_o} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got %b expected 000001", {bclk_o, lrck_o, sdata_o, frame_o, underrun_o, ready_o});
    end
    n = 0;
    while (!frame_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL midrst_latency: got %0d expected 4", n);
    end
    capture(-1, seq, lr, ur, rdy0, rdy_mid, t0, fz, to);
    checks++;
    if (to || ur !== 1'b1 || seq !== 20'h0) begin
      errors++;
      $display("[TB] FAIL midrst_frame: underrun %b data %h expected 1 00000", ur, seq);
    end
  endtask

  initial begin
    test_reset();
    test_normal_stream();
    test_underrun();
    test_simultaneous();
    test_back_to_back();
    test_en_gating();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
